// File: rtl/air_board_ctrl.sv
// Board-support block: reset stretch/sync, debounced card detect, SD power
// sequencing with software power-cycle, and heartbeat/status LEDs.
module air_board_ctrl #(
  parameter int RESET_HOLD_CYCLES = 1000,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int PWR_ON_CYCLES     = 2500000,
  parameter int PWR_OFF_CYCLES    = 2500000,
  parameter int HEARTBEAT_CYCLES  = 25000000,
  parameter int LED_NUM           = 2
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               SW_CD_N,
  input  logic               sd_off_req,
  output logic               reset_out,
  output logic               SD_PWR_N,
  output logic               sd_ready,
  output logic               card_present,
  output logic               card_event,
  output logic [LED_NUM-1:0] USER_LED
);

  localparam int HOLD_W  = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PWR_MAX = (PWR_ON_CYCLES > PWR_OFF_CYCLES) ? PWR_ON_CYCLES : PWR_OFF_CYCLES;
  localparam int PWR_W   = $clog2(PWR_MAX + 1);
  localparam int HB_W    = $clog2(HEARTBEAT_CYCLES + 1);
  localparam int QTR     = HEARTBEAT_CYCLES / 4;
  localparam int QTR_W   = $clog2(QTR + 1);

  typedef enum logic [2:0] {S_RST, S_NOCARD, S_PWRUP, S_READY, S_PWROFF} state_t;

  logic [1:0]        rst_sync_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              reset_out_reg;
  logic              hold_done;
  logic [1:0]        cd_sync_reg;
  logic [DEB_W-1:0]  deb_cnt_reg;
  logic              card_present_reg;
  logic              card_event_reg;
  logic              cd_sample;
  state_t            state_reg, state_next;
  logic [PWR_W-1:0]  pwr_cnt_reg, pwr_cnt_next;
  logic              sd_pwr_n_reg, sd_pwr_n_next;
  logic              sd_ready_reg, sd_ready_next;
  logic [HB_W-1:0]   presc_reg;
  logic [QTR_W-1:0]  qtr_cnt_reg;
  logic              hb_phase_reg;
  logic              fast_phase_reg;

  // The FSM leaves S_RST on the very edge that releases reset_out.
  assign hold_done = rst_sync_reg[1] && reset_out_reg &&
                     (hold_cnt_reg == HOLD_W'(RESET_HOLD_CYCLES - 1));

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_sync_reg  <= 2'b00;
      hold_cnt_reg  <= '0;
      reset_out_reg <= 1'b1;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
      if (hold_done)
        reset_out_reg <= 1'b0;
      else if (rst_sync_reg[1] && reset_out_reg)
        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
    end
  end

  assign cd_sample = ~cd_sync_reg[1];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cd_sync_reg      <= 2'b11;
      deb_cnt_reg      <= '0;
      card_present_reg <= 1'b0;
      card_event_reg   <= 1'b0;
    end else begin
      cd_sync_reg    <= {cd_sync_reg[0], SW_CD_N};
      card_event_reg <= 1'b0;
      if (cd_sample == card_present_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_cnt_reg      <= '0;
        card_present_reg <= ~card_present_reg;
        card_event_reg   <= 1'b1;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= S_RST;
      pwr_cnt_reg  <= '0;
      sd_pwr_n_reg <= 1'b1;
      sd_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pwr_cnt_reg  <= pwr_cnt_next;
      sd_pwr_n_reg <= sd_pwr_n_next;
      sd_ready_reg <= sd_ready_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pwr_cnt_next = pwr_cnt_reg;
    case (state_reg)
      S_RST:
        if (hold_done) state_next = S_NOCARD;
      S_NOCARD:
        if (card_present_reg) begin
          state_next   = S_PWRUP;
          pwr_cnt_next = PWR_W'(PWR_ON_CYCLES);
        end
      S_PWRUP:
        if (!card_present_reg || sd_off_req) begin
          state_next   = S_PWROFF;
          pwr_cnt_next = PWR_W'(PWR_OFF_CYCLES);
        end else begin
          pwr_cnt_next = pwr_cnt_reg - PWR_W'(1);
          if (pwr_cnt_reg == PWR_W'(1)) state_next = S_READY;
        end
      S_READY:
        if (!card_present_reg || sd_off_req) begin
          state_next   = S_PWROFF;
          pwr_cnt_next = PWR_W'(PWR_OFF_CYCLES);
        end
      S_PWROFF: begin
        // Off time is fixed: neither requests nor card changes shorten it.
        pwr_cnt_next = pwr_cnt_reg - PWR_W'(1);
        if (pwr_cnt_reg == PWR_W'(1)) state_next = S_NOCARD;
      end
      default: state_next = S_RST;
    endcase
  end

  always_comb begin
    sd_pwr_n_next = !((state_next == S_PWRUP) || (state_next == S_READY));
    sd_ready_next = (state_next == S_READY);
  end

  // Prescalers restart at reset release so the blink phase is deterministic.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_reg      <= '0;
      qtr_cnt_reg    <= '0;
      hb_phase_reg   <= 1'b0;
      fast_phase_reg <= 1'b0;
    end else if (reset_out_reg) begin
      presc_reg      <= '0;
      qtr_cnt_reg    <= '0;
      hb_phase_reg   <= 1'b0;
      fast_phase_reg <= 1'b0;
    end else begin
      if (presc_reg == HB_W'(HEARTBEAT_CYCLES - 1)) begin
        presc_reg    <= '0;
        hb_phase_reg <= ~hb_phase_reg;
      end else begin
        presc_reg <= presc_reg + HB_W'(1);
      end
      if (qtr_cnt_reg == QTR_W'(QTR - 1)) begin
        qtr_cnt_reg    <= '0;
        fast_phase_reg <= ~fast_phase_reg;
      end else begin
        qtr_cnt_reg <= qtr_cnt_reg + QTR_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LED_NUM; gi++) begin : g_led
      if (gi == 0) begin : g_hb
        assign USER_LED[gi] = hb_phase_reg & ~reset_out_reg;
      end else if (gi == 1) begin : g_status
        assign USER_LED[gi] = (state_reg == S_READY) ||
                              ((state_reg == S_PWRUP) && fast_phase_reg);
      end else begin : g_off
        assign USER_LED[gi] = 1'b0;
      end
    end
  endgenerate

  assign reset_out    = reset_out_reg;
  assign SD_PWR_N     = sd_pwr_n_reg;
  assign sd_ready     = sd_ready_reg;
  assign card_present = card_present_reg;
  assign card_event   = card_event_reg;

endmodule

// File: tb/tb_air_board_ctrl.sv
// Scoreboard bench: stimulus pushes expected event cycles, a negedge monitor
// pops and compares them whenever the DUT produces an output edge.
module tb_air_board_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N = 1'b0;
  logic       SW_CD_N = 1'b1;
  logic       sd_off_req = 1'b0;
  logic       reset_out, SD_PWR_N, sd_ready, card_present, card_event;
  logic [2:0] USER_LED;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit done = 1'b0;

  int rst_q[$];
  int evt_q[$];
  int on_q[$];
  int off_q[$];
  int rdy_q[$];
  int nrdy_q[$];

  air_board_ctrl #(
    .RESET_HOLD_CYCLES(8),
    .DEBOUNCE_CYCLES(4),
    .PWR_ON_CYCLES(16),
    .PWR_OFF_CYCLES(10),
    .HEARTBEAT_CYCLES(8),
    .LED_NUM(3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N(RESET_N),
    .SW_CD_N(SW_CD_N),
    .sd_off_req(sd_off_req),
    .reset_out(reset_out),
    .SD_PWR_N(SD_PWR_N),
    .sd_ready(sd_ready),
    .card_present(card_present),
    .card_event(card_event),
    .USER_LED(USER_LED)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: every observed output edge must match the head of its queue.
  logic prev_rst = 1'b1, prev_pwr_n = 1'b1, prev_rdy = 1'b0;
  int   mon_exp;
  always @(negedge CLOCK_50) begin
    if (prev_rst && !reset_out) begin
      mon_exp = (rst_q.size() > 0) ? rst_q.pop_front() : -1;
      check("reset_out_fall", cyc, mon_exp);
    end
    if (card_event) begin
      mon_exp = (evt_q.size() > 0) ? evt_q.pop_front() : -1;
      check("card_event", cyc, mon_exp);
    end
    if (prev_pwr_n && !SD_PWR_N) begin
      mon_exp = (on_q.size() > 0) ? on_q.pop_front() : -1;
      check("pwr_on", cyc, mon_exp);
    end
    if (!prev_pwr_n && SD_PWR_N) begin
      mon_exp = (off_q.size() > 0) ? off_q.pop_front() : -1;
      check("pwr_off", cyc, mon_exp);
    end
    if (!prev_rdy && sd_ready) begin
      mon_exp = (rdy_q.size() > 0) ? rdy_q.pop_front() : -1;
      check("ready_rise", cyc, mon_exp);
    end
    if (prev_rdy && !sd_ready) begin
      mon_exp = (nrdy_q.size() > 0) ? nrdy_q.pop_front() : -1;
      check("ready_fall", cyc, mon_exp);
    end
    prev_rst   = reset_out;
    prev_pwr_n = SD_PWR_N;
    prev_rdy   = sd_ready;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: got 0 expected 1 (bench did not complete)");
      $fatal(1, "timeout");
    end
  end

  int c;
  int last_tog, n_tog;
  logic prev_led;
  logic led1_hist [0:31];

  initial begin
    // Reset held: every output at its reset value.
    wait_cycles(3);
    check("rst_reset_out", reset_out, 1);
    check("rst_sd_pwr_n", SD_PWR_N, 1);
    check("rst_sd_ready", sd_ready, 0);
    check("rst_card_present", card_present, 0);
    check("rst_card_event", card_event, 0);
    check("rst_user_led", USER_LED, 0);

    // Release: reset_out falls on edge 10, then heartbeat every 8 cycles.
    c = cyc;
    RESET_N = 1'b1;
    rst_q.push_back(c + 10);
    wait_cycles(9);
    check("hold_user_led", USER_LED, 0);
    check("hold_reset_out", reset_out, 1);
    wait_cycles(1);
    check("rel_led0", USER_LED[0], 0);
    check("rel_sd_pwr_n", SD_PWR_N, 1);
    prev_led = USER_LED[0];
    last_tog = -1;
    n_tog = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLOCK_50);
      if (USER_LED[0] !== prev_led) begin
        if (last_tog >= 0) check("hb_period", cyc - last_tog, 8);
        last_tog = cyc;
        n_tog++;
      end
      prev_led = USER_LED[0];
    end
    check("hb_toggle_count", n_tog, 4);

    // Bounce: no accepted change, no event (monitor flags any stray one).
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (i % 2 == 0) SW_CD_N = ~SW_CD_N;
    end
    @(negedge CLOCK_50);
    SW_CD_N = 1'b1;
    wait_cycles(8);
    check("bounce_card_present", card_present, 0);

    // Insertion: event at +6, power on at +7, ready 16 cycles later.
    @(negedge CLOCK_50);
    c = cyc;
    SW_CD_N = 1'b0;
    evt_q.push_back(c + 6);
    on_q.push_back(c + 7);
    rdy_q.push_back(c + 23);
    for (int k = 1; k <= 28; k++) begin
      @(negedge CLOCK_50);
      led1_hist[k] = USER_LED[1];
      check("led2_off", USER_LED[2], 0);
      if (k == 5) check("led1_nocard", USER_LED[1], 0);
      if (k == 6) check("card_present_rise", card_present, 1);
      if (k >= 9 && k <= 22) check("led1_blink", led1_hist[k], !led1_hist[k-2]);
      if (k >= 24) check("led1_ready", USER_LED[1], 1);
    end

    // Software power cycle, with a second request ignored during off time.
    @(negedge CLOCK_50);
    c = cyc;
    sd_off_req = 1'b1;
    off_q.push_back(c + 1);
    nrdy_q.push_back(c + 1);
    on_q.push_back(c + 12);
    rdy_q.push_back(c + 28);
    @(negedge CLOCK_50);
    sd_off_req = 1'b0;
    check("offreq_sd_ready", sd_ready, 0);
    wait_cycles(3);
    sd_off_req = 1'b1;
    @(negedge CLOCK_50);
    sd_off_req = 1'b0;
    wait_cycles(28);

    // Removal on cycle 7 of power-up, reinsertion during off time.
    @(negedge CLOCK_50);
    c = cyc;
    sd_off_req = 1'b1;
    off_q.push_back(c + 1);
    nrdy_q.push_back(c + 1);
    on_q.push_back(c + 12);
    @(negedge CLOCK_50);
    sd_off_req = 1'b0;
    wait_cycles(11);
    SW_CD_N = 1'b1;
    evt_q.push_back(c + 18);
    off_q.push_back(c + 19);
    wait_cycles(8);
    SW_CD_N = 1'b0;
    evt_q.push_back(c + 26);
    on_q.push_back(c + 30);
    rdy_q.push_back(c + 46);
    wait_cycles(30);
    check("reinsert_sd_ready", sd_ready, 1);

    // Asynchronous reset in S_READY: immediate safe state, full resequence.
    @(negedge CLOCK_50);
    c = cyc;
    #2 RESET_N = 1'b0;
    off_q.push_back(c + 1);
    nrdy_q.push_back(c + 1);
    #1;
    check("async_sd_pwr_n", SD_PWR_N, 1);
    check("async_sd_ready", sd_ready, 0);
    check("async_reset_out", reset_out, 1);
    check("async_user_led", USER_LED, 0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    rst_q.push_back(c + 11);
    evt_q.push_back(c + 7);
    on_q.push_back(c + 12);
    rdy_q.push_back(c + 28);
    wait_cycles(34);

    check("q_rst_empty", rst_q.size(), 0);
    check("q_evt_empty", evt_q.size(), 0);
    check("q_on_empty", on_q.size(), 0);
    check("q_off_empty", off_q.size(), 0);
    check("q_rdy_empty", rdy_q.size(), 0);
    check("q_nrdy_empty", nrdy_q.size(), 0);

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
